fwd_hazard_unit: RTL

Parametrised successor to the pipeline forwarding control. Generates per-operand forwarding selects for NUM_SRC source operands in ID/EX, and adds load-use hazard detection with a multi-cycle stall FSM that supports configurable load latency. Sits between the ID and EX stages and drives the PC/IF-ID hold and the ID/EX bubble insertion.

---
 rtl/fwd_hazard_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects plus load-use hazard stall/flush control for the ID/EX boundary.
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle counter output.
module fwd_hazard_unit #(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int LOAD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ctl_reg_write_EXMEM_i,
    input  logic                     ctl_reg_write_MEMWB_i,
    input  logic [REG_W-1:0]         reg_dest_EXMEM_i,
    input  logic [REG_W-1:0]         reg_dest_MEMWB_i,
    input  logic                     ctl_reg_write_IDEX_i,
    input  logic                     ctl_mem_read_IDEX_i,
    input  logic [REG_W-1:0]         reg_dest_IDEX_i,
    input  logic [NUM_SRC*REG_W-1:0] reg_src_IDEX_i,
    input  logic [NUM_SRC*REG_W-1:0] reg_src_IFID_i,
    input  logic [NUM_SRC-1:0]       src_used_IFID_i,
    output logic [2*NUM_SRC-1:0]     forward_o,
    output logic                     stall_o,
`ifdef STALL_CNT_EN
    output logic [31:0]              stall_cnt_o,
`endif
    output logic                     flush_IDEX_o
);

    if ((NUM_SRC < 1) || (NUM_SRC > 4)) begin : g_bad_num_src
        $error("fwd_hazard_unit: NUM_SRC must be in 1..4");
    end
    if ((LOAD_LAT < 1) || (LOAD_LAT > 4)) begin : g_bad_load_lat
        $error("fwd_hazard_unit: LOAD_LAT must be in 1..4");
    end

    typedef enum logic [0:0] {IDLE = 1'b0, STALL = 1'b1} state_t;

    localparam bit         MULTI_CYCLE = (LOAD_LAT > 1);
    localparam logic [1:0] CNT_INIT    = (LOAD_LAT > 1) ? 2'(LOAD_LAT - 2) : 2'd0;

    state_t                 state_r, state_nxt_s;
    logic [1:0]             cnt_r, cnt_nxt_s;
    logic                   hz_s;
    logic                   stall_s;
    logic [2*NUM_SRC-1:0]   fwd_s;

    // A non-writing EX/MEM never shadows a valid MEM/WB result.
    function automatic logic [1:0] fwd_sel(
        input logic             ex_wr,
        input logic [REG_W-1:0] ex_dest,
        input logic             wb_wr,
        input logic [REG_W-1:0] wb_dest,
        input logic [REG_W-1:0] src
    );
        logic ex_hit, wb_hit;
        ex_hit = ex_wr && (ex_dest != {REG_W{1'b0}}) && (ex_dest == src);
        wb_hit = wb_wr && (wb_dest != {REG_W{1'b0}}) && (wb_dest == src);
        if (ex_hit) begin
            fwd_sel = 2'b10;
        end else if (wb_hit) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // Per-operand forwarding selects, forced to register-file while in reset.
    always_comb begin
        fwd_s = {(2*NUM_SRC){1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            if (reset) begin
                fwd_s[2*k +: 2] = 2'b00;
            end else begin
                fwd_s[2*k +: 2] = fwd_sel(ctl_reg_write_EXMEM_i, reg_dest_EXMEM_i,
                                          ctl_reg_write_MEMWB_i, reg_dest_MEMWB_i,
                                          reg_src_IDEX_i[k*REG_W +: REG_W]);
            end
        end
    end

    // Load-use detection against every operand the IF/ID instruction actually reads.
    always_comb begin
        logic match_v;
        match_v = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            match_v = match_v | (src_used_IFID_i[k] &&
                                 (reg_src_IFID_i[k*REG_W +: REG_W] == reg_dest_IDEX_i));
        end
        hz_s = ctl_mem_read_IDEX_i && ctl_reg_write_IDEX_i &&
               (reg_dest_IDEX_i != {REG_W{1'b0}}) && match_v;
    end

    // Stall FSM next-state: the detection cycle is the first stall cycle, STALL covers the rest.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        stall_s     = 1'b0;
        case (state_r)
            IDLE: begin
                stall_s = hz_s;
                if (hz_s && MULTI_CYCLE) begin
                    state_nxt_s = STALL;
                    cnt_nxt_s   = CNT_INIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            STALL: begin
                stall_s = 1'b1;
                if (cnt_r == 2'd0) begin
                    state_nxt_s = IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // Stall FSM state and countdown registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    assign forward_o    = fwd_s;
    assign stall_o      = stall_s & ~reset;
    assign flush_IDEX_o = stall_s & ~reset;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_o && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`endif

endmodule
